// File: rtl/onchip_mem_arb_pkg.sv
// Shared types for the two-master on-chip RAM arbiter.
// Master ids, the read-return tag and the default RAM depth.
package onchip_mem_arb_pkg;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } mid_t;

   typedef struct packed {
      logic pend;
      mid_t id;
      logic oor;
   } rd_tag_t;

   localparam int DEFAULT_NUM_WORDS = 87500;

endpackage

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-request round-robin grant; last_gnt resets to M1 so m0 wins
// the first conflict.
module rr_arb2
   import onchip_mem_arb_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic req0,
   input  logic req1,
   output logic gnt_any,
   output mid_t gnt_id
);

   mid_t last_gnt;

   always_comb begin
      gnt_any = req0 | req1;
      gnt_id  = M0;
      if (req0 && req1) begin
         gnt_id = (last_gnt == M1) ? M0 : M1;
      end else if (req1) begin
         gnt_id = M1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_gnt <= M1;
      end else if (gnt_any) begin
         last_gnt <= gnt_id;
      end
   end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two Avalon-MM masters.
// Optional perf counters: define ONCHIP_MEM_ARB_PERF_CNT_EN.
module onchip_mem_arbiter
   import onchip_mem_arb_pkg::*;
#(
   parameter int ADDR_W    = 17,
   parameter int DATA_W    = 32,
   parameter int BE_W      = DATA_W / 8,
   parameter int NUM_WORDS = DEFAULT_NUM_WORDS
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   input  logic [BE_W-1:0]   m0_byteenable,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   input  logic [BE_W-1:0]   m1_byteenable,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
`ifdef ONCHIP_MEM_ARB_PERF_CNT_EN
   output logic [31:0]       perf_gnt0,
   output logic [31:0]       perf_gnt1,
   output logic [31:0]       perf_stall1,
`endif
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_WORDS);

   logic              req0;
   logic              req1;
   logic              gnt_any;
   mid_t              gnt_id;
   logic              gnt0;
   logic              gnt1;
   logic              sel_read;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [BE_W-1:0]   sel_be;
   logic              in_range;
   rd_tag_t           rd_d;
   rd_tag_t           rd_q;

   // Requests are masked during reset so nothing reaches the RAM.
   assign req0 = reset_n & (m0_read | m0_write);
   assign req1 = reset_n & (m1_read | m1_write);

   rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req0    (req0),
      .req1    (req1),
      .gnt_any (gnt_any),
      .gnt_id  (gnt_id)
   );

   assign gnt0 = gnt_any & (gnt_id == M0);
   assign gnt1 = gnt_any & (gnt_id == M1);

   always_comb begin
      sel_read  = m0_read;
      sel_write = m0_write;
      sel_addr  = m0_address;
      sel_wdata = m0_writedata;
      sel_be    = m0_byteenable;
      if (gnt_id == M1) begin
         sel_read  = m1_read;
         sel_write = m1_write;
         sel_addr  = m1_address;
         sel_wdata = m1_writedata;
         sel_be    = m1_byteenable;
      end
   end

   assign in_range = {1'b0, sel_addr} < LIMIT;

   always_comb begin
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_writedata  = '0;
      mem_byteenable = '0;
      if (gnt_any) begin
         mem_chipselect = 1'b1;
         mem_write      = sel_write & in_range;
         mem_address    = sel_addr;
         mem_writedata  = sel_wdata;
         mem_byteenable = sel_be;
      end
   end

   assign mem_clken = 1'b1;

   assign m0_waitrequest = req0 & ~gnt0;
   assign m1_waitrequest = req1 & ~gnt1;

   // Write wins over a simultaneous read.
   always_comb begin
      rd_d.pend = gnt_any & sel_read & ~sel_write;
      rd_d.id   = gnt_id;
      rd_d.oor  = ~in_range;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_q <= '{pend: 1'b0, id: M0, oor: 1'b0};
      end else begin
         rd_q <= rd_d;
      end
   end

   assign m0_readdatavalid = rd_q.pend & (rd_q.id == M0);
   assign m1_readdatavalid = rd_q.pend & (rd_q.id == M1);
   assign m0_readdata = (m0_readdatavalid && !rd_q.oor) ? mem_readdata : '0;
   assign m1_readdata = (m1_readdatavalid && !rd_q.oor) ? mem_readdata : '0;

`ifdef ONCHIP_MEM_ARB_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_gnt0   <= '0;
         perf_gnt1   <= '0;
         perf_stall1 <= '0;
      end else begin
         if (gnt0 && perf_gnt0 != '1) begin
            perf_gnt0 <= perf_gnt0 + 32'd1;
         end
         if (gnt1 && perf_gnt1 != '1) begin
            perf_gnt1 <= perf_gnt1 + 32'd1;
         end
         if (m1_waitrequest && perf_stall1 != '1) begin
            perf_stall1 <= perf_stall1 + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a small behavioural RAM.
// Inputs change 1 time unit after posedge; outputs sampled before the next edge.
module tb_onchip_mem_arbiter;

   logic        clk;
   logic        reset_n;
   logic [16:0] m0_address;
   logic        m0_read;
   logic        m0_write;
   logic [31:0] m0_writedata;
   logic [3:0]  m0_byteenable;
   logic        m0_waitrequest;
   logic [31:0] m0_readdata;
   logic        m0_readdatavalid;
   logic [16:0] m1_address;
   logic        m1_read;
   logic        m1_write;
   logic [31:0] m1_writedata;
   logic [3:0]  m1_byteenable;
   logic        m1_waitrequest;
   logic [31:0] m1_readdata;
   logic        m1_readdatavalid;
   logic [16:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        mem_clken;
   logic [31:0] mem_readdata;
`ifdef ONCHIP_MEM_ARB_PERF_CNT_EN
   logic [31:0] perf_gnt0;
   logic [31:0] perf_gnt1;
   logic [31:0] perf_stall1;
`endif

   int total;
   int bad;

   logic [31:0] ram [256];

   onchip_mem_arbiter dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .m0_address       (m0_address),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_byteenable    (m0_byteenable),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_byteenable    (m1_byteenable),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
`ifdef ONCHIP_MEM_ARB_PERF_CNT_EN
      .perf_gnt0        (perf_gnt0),
      .perf_gnt1        (perf_gnt1),
      .perf_stall1      (perf_stall1),
`endif
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_clken        (mem_clken),
      .mem_readdata     (mem_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM model, low 8 address bits, old data on q.
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_byteenable[b]) begin
                  ram[mem_address[7:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
               end
            end
         end
         mem_readdata <= ram[mem_address[7:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m0_read  = 1'b0;
      m0_write = 1'b0;
      m1_read  = 1'b0;
      m1_write = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_wr0"}, 32'(m0_waitrequest), 32'd0);
      chk({tag, "_wr1"}, 32'(m1_waitrequest), 32'd0);
      chk({tag, "_rv0"}, 32'(m0_readdatavalid), 32'd0);
      chk({tag, "_rv1"}, 32'(m1_readdatavalid), 32'd0);
      chk({tag, "_rd0"}, m0_readdata, 32'd0);
      chk({tag, "_rd1"}, m1_readdata, 32'd0);
      chk({tag, "_cs"}, 32'(mem_chipselect), 32'd0);
      chk({tag, "_mw"}, 32'(mem_write), 32'd0);
      chk({tag, "_clken"}, 32'(mem_clken), 32'd1);
   endtask

   initial begin
      logic [16:0] exp_addr;
      total = 0;
      bad = 0;
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      ram[8'h10] = 32'hDEADBEEF;
      ram[8'h20] = 32'hAAAAAAAA;
      mem_readdata  = '0;
      reset_n       = 1'b0;
      idle();
      m0_address    = '0;
      m1_address    = '0;
      m0_writedata  = '0;
      m1_writedata  = '0;
      m0_byteenable = 4'hF;
      m1_byteenable = 4'hF;
      tick();
      tick();
      chk_reset_vals("rst");
      reset_n = 1'b1;
      tick();

      // m0 read of preloaded word
      m0_address = 17'h00010;
      m0_read    = 1'b1;
      #1;
      chk("rd0_addr", 32'(mem_address), 32'h10);
      chk("rd0_cs", 32'(mem_chipselect), 32'd1);
      chk("rd0_wait", 32'(m0_waitrequest), 32'd0);
      tick();
      idle();
      chk("rd0_valid", 32'(m0_readdatavalid), 32'd1);
      chk("rd0_data", m0_readdata, 32'hDEADBEEF);
      chk("rd0_v1", 32'(m1_readdatavalid), 32'd0);

      // m1 read moves last grant to m1
      tick();
      chk("idle_v0", 32'(m0_readdatavalid), 32'd0);
      m1_address = 17'h00020;
      m1_read    = 1'b1;
      tick();
      idle();
      chk("rd1_valid", 32'(m1_readdatavalid), 32'd1);
      chk("rd1_data", m1_readdata, 32'hAAAAAAAA);
      chk("rd1_v0", 32'(m0_readdatavalid), 32'd0);

      // conflicting writes alternate m0, m1, m0, m1
      m0_address   = 17'h00030;
      m0_writedata = 32'h0000_0030;
      m1_address   = 17'h00040;
      m1_writedata = 32'h0000_0040;
      m0_write     = 1'b1;
      m1_write     = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         exp_addr = (c % 2 == 0) ? 17'h00030 : 17'h00040;
         chk($sformatf("cf%0d_w0", c), 32'(m0_waitrequest), 32'(c % 2));
         chk($sformatf("cf%0d_w1", c), 32'(m1_waitrequest), 32'((c + 1) % 2));
         chk($sformatf("cf%0d_addr", c), 32'(mem_address), 32'(exp_addr));
         chk($sformatf("cf%0d_mw", c), 32'(mem_write), 32'd1);
         tick();
      end
      idle();
      chk("cf_ram30", ram[8'h30], 32'h30);
      chk("cf_ram40", ram[8'h40], 32'h40);

      // m1 partial write then read back
      m1_address    = 17'h00020;
      m1_writedata  = 32'h12345678;
      m1_byteenable = 4'h3;
      m1_write      = 1'b1;
      #1;
      chk("pw_mw", 32'(mem_write), 32'd1);
      chk("pw_be", 32'(mem_byteenable), 32'h3);
      tick();
      idle();
      m1_byteenable = 4'hF;
      m1_read       = 1'b1;
      tick();
      idle();
      chk("pw_valid", 32'(m1_readdatavalid), 32'd1);
      chk("pw_data", m1_readdata, 32'hAAAA5678);

      // out of range: write dropped, read returns zero
      m0_address   = 17'h155CC;
      m0_writedata = 32'hFFFFFFFF;
      m0_write     = 1'b1;
      #1;
      chk("oor_wait", 32'(m0_waitrequest), 32'd0);
      chk("oor_cs", 32'(mem_chipselect), 32'd1);
      chk("oor_mw", 32'(mem_write), 32'd0);
      tick();
      m0_write = 1'b0;
      m0_read  = 1'b1;
      #1;
      chk("oor_rmw", 32'(mem_write), 32'd0);
      tick();
      idle();
      chk("oor_valid", 32'(m0_readdatavalid), 32'd1);
      chk("oor_data", m0_readdata, 32'd0);

      // last in-range word is writable
      m0_address = 17'h155CB;
      m0_write   = 1'b1;
      #1;
      chk("top_mw", 32'(mem_write), 32'd1);
      tick();
      idle();

      // reset while a read is pending
      m0_address = 17'h00010;
      m0_read    = 1'b1;
      tick();
      idle();
      reset_n = 1'b0;
      #1;
      chk("rr_v0_now", 32'(m0_readdatavalid), 32'd0);
      tick();
      chk_reset_vals("rr");
      reset_n = 1'b1;
      tick();
      chk("rr_v0_a", 32'(m0_readdatavalid), 32'd0);
      tick();
      chk("rr_v0_b", 32'(m0_readdatavalid), 32'd0);
      chk_reset_vals("rr_post");

`ifdef ONCHIP_MEM_ARB_PERF_CNT_EN
      chk("pc_init", perf_gnt0, 32'd0);
      m0_address = 17'h00050;
      m1_address = 17'h00060;
      m0_write   = 1'b1;
      m1_write   = 1'b1;
      repeat (10) tick();
      idle();
      chk("pc_gnt0", perf_gnt0, 32'd5);
      chk("pc_gnt1", perf_gnt1, 32'd5);
      chk("pc_stall1", perf_stall1, 32'd5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
